// File: rtl/tree_plru_policy_if.sv
// Request/response bundle for the replacement-policy unit.
// master = cache controller side, slave = policy unit.
interface tree_plru_policy_if #(
  parameter int S_INDEX = 3,
  parameter int S_WAY   = 2
);
  localparam int NUM_WAY = 2**S_WAY;

  logic                 flush;
  logic                 busy;
  logic                 touch;
  logic [S_INDEX-1:0]   touch_set;
  logic [S_WAY-1:0]     touch_way;
  logic                 query;
  logic [S_INDEX-1:0]   query_set;
  logic [NUM_WAY-1:0]   valid_mask;
  logic [NUM_WAY-1:0]   lock_mask;
  logic                 victim_valid;
  logic [S_WAY-1:0]     victim_way;
  logic                 no_victim;

  modport master (
    output flush, touch, touch_set, touch_way, query, query_set, valid_mask, lock_mask,
    input  busy, victim_valid, victim_way, no_victim
  );

  modport slave (
    input  flush, touch, touch_set, touch_way, query, query_set, valid_mask, lock_mask,
    output busy, victim_valid, victim_way, no_victim
  );
endinterface

// File: rtl/tree_plru_policy.sv
// Per-set replacement policy (tree-PLRU or MRU-bit) with registered victim
// selection and a one-set-per-cycle flush sweep.
module tree_plru_policy #(
  parameter int S_INDEX = 3,
  parameter int S_WAY   = 2,
  parameter int MODE    = 0
) (
  input  logic            clk,
  input  logic            rst,
  tree_plru_policy_if.slave bus
);
  localparam int NUM_SETS = 2**S_INDEX;
  localparam int NUM_WAY  = 2**S_WAY;
  localparam int NB       = (MODE == 1) ? NUM_WAY : NUM_WAY - 1;
  localparam logic [S_INDEX-1:0] LAST_SET = S_INDEX'(NUM_SETS - 1);

  typedef enum logic {ST_IDLE, ST_SWEEP} fsm_t;

  fsm_t                       r_fsm, w_fsm_nxt;
  logic [S_INDEX-1:0]         r_cnt;
  logic                       w_busy;
  logic [NUM_SETS-1:0][NB-1:0] r_plru;
  logic [NB-1:0]              w_touch_nxt;
  logic [NB-1:0]              w_qstate;
  logic [S_WAY-1:0]           w_pol_way;
  logic [S_WAY-1:0]           w_sel_way;
  logic                       w_sel_none;
  logic [NUM_WAY-1:0]         w_free;
  logic [NUM_WAY-1:0]         w_unl;
  logic                       w_touch_en;
  logic                       w_accept;
  logic                       r_vv;
  logic [S_WAY-1:0]           r_vway;
  logic                       r_nv;

  // Flush FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_fsm <= ST_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // Flush FSM next state: a flush during the sweep restarts it, so stay put
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_IDLE:  if (bus.flush) w_fsm_nxt = ST_SWEEP;
      ST_SWEEP: if (!bus.flush && r_cnt == LAST_SET) w_fsm_nxt = ST_IDLE;
    endcase
  end

  // Flush FSM outputs
  always_comb begin
    w_busy = (r_fsm == ST_SWEEP);
  end

  // Sweep pointer: set being cleared this busy cycle; wraps to 0 after the last set
  always_ff @(posedge clk) begin
    if (rst || !w_busy || bus.flush) r_cnt <= '0;
    else                             r_cnt <= r_cnt + 1'b1;
  end

  // Touches and queries are only honoured outside the sweep
  always_comb begin
    w_touch_en = bus.touch && !w_busy;
    w_accept   = bus.query && !w_busy;
  end

  if (MODE == 1) begin : g_mru
    // MRU touch: mark the way; if every way is now marked, keep only this one
    always_comb begin
      w_touch_nxt = r_plru[bus.touch_set];
      w_touch_nxt[bus.touch_way] = 1'b1;
      if (&w_touch_nxt) begin
        w_touch_nxt = '0;
        w_touch_nxt[bus.touch_way] = 1'b1;
      end
    end

    // MRU policy: lowest way whose bit is clear (one always exists after a touch)
    always_comb begin
      w_pol_way = '0;
      for (int i = NUM_WAY - 1; i >= 0; i--)
        if (!w_qstate[i]) w_pol_way = S_WAY'(i);
    end
  end else begin : g_tree
    // Tree touch: every node on the way's root-to-leaf path points to the other half
    always_comb begin
      int   node;
      logic b;
      w_touch_nxt = r_plru[bus.touch_set];
      node = 0;
      for (int l = 0; l < S_WAY; l++) begin
        b = bus.touch_way[S_WAY-1-l];
        w_touch_nxt[node] = ~b;
        node = 2 * node + 1 + int'(b);
      end
    end

    // Tree walk from the root; each node bit selects the half, MSB first
    always_comb begin
      int   node;
      logic b;
      w_pol_way = '0;
      node = 0;
      for (int l = 0; l < S_WAY; l++) begin
        b = w_qstate[node];
        w_pol_way[S_WAY-1-l] = b;
        node = 2 * node + 1 + int'(b);
      end
    end
  end

  // Query sees the post-touch state when a same-set touch lands this cycle
  always_comb begin
    if (w_touch_en && bus.touch_set == bus.query_set) w_qstate = w_touch_nxt;
    else                                              w_qstate = r_plru[bus.query_set];
  end

  // Victim priority: free (invalid, unlocked) way, policy way, any unlocked way, none
  always_comb begin
    w_free     = ~bus.valid_mask & ~bus.lock_mask;
    w_unl      = ~bus.lock_mask;
    w_sel_way  = '0;
    w_sel_none = 1'b0;
    if (|w_free) begin
      for (int i = NUM_WAY - 1; i >= 0; i--)
        if (w_free[i]) w_sel_way = S_WAY'(i);
    end else if (!bus.lock_mask[w_pol_way]) begin
      w_sel_way = w_pol_way;
    end else if (|w_unl) begin
      for (int i = NUM_WAY - 1; i >= 0; i--)
        if (w_unl[i]) w_sel_way = S_WAY'(i);
    end else begin
      w_sel_none = 1'b1;
    end
  end

  // Policy state: sweep clears one set per busy cycle, otherwise apply the touch
  always_ff @(posedge clk) begin
    if (rst)             r_plru <= '0;
    else if (w_busy)     r_plru[r_cnt] <= '0;
    else if (w_touch_en) r_plru[bus.touch_set] <= w_touch_nxt;
  end

  // Registered victim response; way holds between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vv   <= 1'b0;
      r_vway <= '0;
      r_nv   <= 1'b0;
    end else begin
      r_vv <= w_accept;
      if (w_accept) begin
        r_vway <= w_sel_way;
        r_nv   <= w_sel_none;
      end
    end
  end

  assign bus.busy         = w_busy;
  assign bus.victim_valid = r_vv;
  assign bus.victim_way   = r_vway;
  assign bus.no_victim    = r_nv & r_vv;
endmodule
